// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DROP_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register for a single demux channel: data, last and valid.
module demux_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  // A load wins over a drain, so valid stays high on a simultaneous drain+load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Packet-aware 1-to-N stream demultiplexer: the first beat's select locks the
// route until the last beat; illegal selects are accepted, dropped and counted.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_last,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [N*W-1:0]    out_data,
  output logic [N-1:0]      out_last,
  output logic [DROP_W-1:0] drop_cnt,
  output state_e            dbg_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // in_ready looks only at the target channel, never at in_valid.

  state_e              state_q, state_d;
  logic [SW-1:0]       lk_sel_q, lk_sel_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [SW-1:0]       target;
  logic                tgt_legal;
  logic                tgt_open;
  logic                xfer;
  logic [N-1:0]        load;

  always_comb begin
    target    = (state_q == LOCKED) ? lk_sel_q : in_sel;
    tgt_legal = 1'b0;
    tgt_open  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (target == SW'(k)) begin
        tgt_legal = 1'b1;
        tgt_open  = ~out_valid[k] | out_ready[k];
      end
    end
  end

  assign in_ready = rst_n & tgt_open;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = xfer && (target == SW'(k));
    end
  end

  always_comb begin
    state_d  = state_q;
    lk_sel_d = lk_sel_q;
    drop_d   = drop_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d  = LOCKED;
            lk_sel_d = in_sel;
          end
        end
        LOCKED: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (!tgt_legal && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lk_sel_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      lk_sel_q <= lk_sel_d;
      drop_q   <= drop_d;
    end
  end

  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

  for (genvar g = 0; g < N; g++) begin : g_chan
    demux_out_reg #(.W(W)) u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[g]),
      .valid_o (out_valid[g]),
      .data_o  (out_data[g*W +: W]),
      .last_o  (out_last[g])
    );
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: a 16-channel instance driven through a scoreboard
// and a 12-channel instance for the illegal-select / drop counter behaviour.
module tb_stream_demux_1xn;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-channel instance
  logic         in_valid, in_ready, in_last;
  logic [7:0]   in_data;
  logic [3:0]   in_sel;
  logic [15:0]  out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [7:0]   drop_cnt;
  state_e       dbg_state;

  // 12-channel instance
  logic        in_valid12, in_ready12, in_last12;
  logic [7:0]  in_data12;
  logic [3:0]  in_sel12;
  logic [11:0] out_valid12, out_ready12, out_last12;
  logic [95:0] out_data12;
  logic [7:0]  drop_cnt12;
  state_e      dbg_state12;

  stream_demux_1xn #(.N(16), .W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  stream_demux_1xn #(.N(12), .W(8)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
    .in_data(in_data12), .in_sel(in_sel12), .in_last(in_last12),
    .out_valid(out_valid12), .out_ready(out_ready12), .out_data(out_data12),
    .out_last(out_last12), .drop_cnt(drop_cnt12), .dbg_state(dbg_state12)
  );

  int total = 0;
  int bad = 0;

  // per-channel expected {last, data}
  logic [8:0] exp_q[16][$];
  logic       locked_m = 1'b0;
  logic [3:0] lk_m = '0;
  logic       rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a beat leaves a channel on the edge where valid and ready are high.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 16; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("sb_extra_ch%0d", k), 32'(exp_q[k].size()), 32'd1);
          end else begin
            chk($sformatf("sb_beat_ch%0d", k), {23'd0, out_last[k], out_data[k*8 +: 8]},
                {23'd0, exp_q[k].pop_front()});
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] sel, input logic [7:0] data, input logic last,
                      output int waits);
    logic [3:0] ch;
    logic       done;
    ch = locked_m ? lk_m : sel;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      if (rand_rdy) out_ready = 16'($urandom);
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        exp_q[ch].push_back({last, data});
        if (!locked_m && !last) begin
          locked_m = 1'b1;
          lk_m     = sel;
        end else if (locked_m && last) begin
          locked_m = 1'b0;
        end
      end else begin
        waits++;
        if (waits > 200) begin
          chk("accept_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w;
    int exp_drop;
    logic [3:0] chs[4];
    in_valid = 0; in_sel = 0; in_data = 0; in_last = 0; out_ready = '1;
    in_valid12 = 0; in_sel12 = 0; in_data12 = 0; in_last12 = 0; out_ready12 = '1;

    // reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {16'd0, out_valid}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // single beat to channel 2
    send(4'h2, 8'hA5, 1'b1, w);
    chk("sb1_valid", {16'd0, out_valid}, 32'h0004);
    chk("sb1_data", {24'd0, out_data[16 +: 8]}, 32'hA5);
    chk("sb1_last", {31'd0, out_last[2]}, 32'd1);
    idle(1);
    chk("sb1_drained", {16'd0, out_valid}, 32'd0);

    // 3-beat packet locked to channel 11
    send(4'hB, 8'h11, 1'b0, w);
    chk("pk_locked", {31'd0, dbg_state}, {31'd0, LOCKED});
    send(4'h3, 8'h22, 1'b0, w);
    chk("pk_ch11_b2", {16'd0, out_valid}, 32'h0800);
    send(4'h3, 8'h33, 1'b1, w);
    chk("pk_ch11_b3", {16'd0, out_valid}, 32'h0800);
    chk("pk_last", {31'd0, out_last[11]}, 32'd1);
    chk("pk_idle", {31'd0, dbg_state}, {31'd0, IDLE});
    idle(1);

    // backpressure on channel 5, then simultaneous drain and load
    out_ready[5] = 1'b0;
    send(4'h5, 8'h55, 1'b1, w);
    in_valid = 1'b1; in_sel = 4'h5; in_data = 8'h66; in_last = 1'b1;
    #1 chk("bp_stall", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_valid", {31'd0, out_valid[5]}, 32'd1);
    chk("bp_hold_data", {24'd0, out_data[40 +: 8]}, 32'h55);
    chk("bp_other_ch", {31'd0, in_ready}, 32'd0);
    out_ready[5] = 1'b1;
    #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
    send(4'h5, 8'h66, 1'b1, w);
    chk("bp_wait", 32'(w), 32'd0);
    chk("bp_valid_kept", {31'd0, out_valid[5]}, 32'd1);
    chk("bp_new_data", {24'd0, out_data[40 +: 8]}, 32'h66);
    idle(1);

    // back-to-back single beats on channel 0 and 15
    chs[0] = 4'h0; chs[1] = 4'hF; chs[2] = 4'h0; chs[3] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send(chs[i], 8'(8'hC0 + i), 1'b1, w);
      chk("b2b_wait", 32'(w), 32'd0);
      chk("b2b_valid", {16'd0, out_valid}, 32'(1) << chs[i]);
    end
    idle(1);
    chk("b2b_empty", {16'd0, out_valid}, 32'd0);

    // random packets under random backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        send(4'($urandom_range(0, 15)), 8'($urandom), (b == len - 1), w);
      end
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    out_ready = '1;
    idle(3);
    for (int k = 0; k < 16; k++) chk($sformatf("rnd_left_ch%0d", k), 32'(exp_q[k].size()), 32'd0);

    // asynchronous reset in the middle of a packet to channel 7
    send(4'h7, 8'h77, 1'b0, w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {16'd0, out_valid}, 32'd0);
    chk("mrst_data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'd0);
    chk("mrst_last", {16'd0, out_last}, 32'd0);
    chk("mrst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 16; k++) exp_q[k].delete();
    locked_m = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'h1, 8'hC1, 1'b1, w);
    chk("mrst_new_valid", {16'd0, out_valid}, 32'h0002);
    chk("mrst_new_data", {24'd0, out_data[8 +: 8]}, 32'hC1);
    idle(2);

    // 12-channel instance: first illegal select, top legal select, saturation
    in_valid12 = 1'b1; in_sel12 = 4'hC; in_data12 = 8'h99; in_last12 = 1'b1;
    @(negedge clk);
    chk("n12_ill_ready", {31'd0, in_ready12}, 32'd1);
    @(posedge clk); #1;
    chk("n12_ill_drop", {24'd0, drop_cnt12}, 32'd1);
    chk("n12_ill_valid", {20'd0, out_valid12}, 32'd0);
    in_sel12 = 4'hB; in_data12 = 8'h5A;
    @(posedge clk); #1;
    chk("n12_ch11_valid", {20'd0, out_valid12}, 32'h800);
    chk("n12_ch11_data", {24'd0, out_data12[88 +: 8]}, 32'h5A);
    chk("n12_ch11_drop", {24'd0, drop_cnt12}, 32'd1);
    in_sel12 = 4'hE;
    for (int i = 0; i < 300; i++) begin
      in_data12 = 8'(i);
      @(negedge clk);
      chk("n12_sat_ready", {31'd0, in_ready12}, 32'd1);
      @(posedge clk); #1;
      chk("n12_sat_valid", {20'd0, out_valid12}, 32'd0);
      exp_drop = (i + 2 > 255) ? 255 : i + 2;
      chk("n12_sat_drop", {24'd0, drop_cnt12}, 32'(exp_drop));
    end
    in_valid12 = 1'b0;
    @(posedge clk); #1;
    chk("n12_final_drop", {24'd0, drop_cnt12}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1xn.md
STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter N, default 16, is the number of output channels, legal range 2..16 and not required to be a power of two.
REQ-002 Parameter W, default 8, is the data width in bits.
REQ-003 Constant SW = max(1, clog2(N)) SHALL set the select width.
REQ-004 Port clk, input, 1 bit, is the single clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1 bit, is the reset: asynchronous and active-low.
REQ-006 Port in_valid, input, 1 bit, means the upstream beat is valid.
REQ-007 Port in_ready, output, 1 bit, means the block accepts the beat this cycle.
REQ-008 Port in_data, input, W bits, is the beat payload.
REQ-009 Port in_sel, input, SW bits, is the destination channel, sampled on the first beat of a packet.
REQ-010 Port in_last, input, 1 bit, marks the final beat of a packet.
REQ-011 Port out_valid, output, N bits, is the per-channel valid.
REQ-012 Port out_ready, input, N bits, is the per-channel downstream ready.
REQ-013 Port out_data, output, N*W bits, is the per-channel payload; channel k occupies bits [k*W +: W].
REQ-014 Port out_last, output, N bits, is the per-channel last flag.
REQ-015 Port drop_cnt, output, 8 bits, is a saturating count of beats dropped for an illegal select.

Function
REQ-016 A beat SHALL transfer when in_valid and in_ready are both 1 on a rising clk edge.
REQ-017 The FSM SHALL have two states: IDLE (no packet open) and LOCKED (packet open).
- The target channel is in_sel in IDLE and the latched select lk_sel in LOCKED.
REQ-018 A transfer in IDLE with in_last=0 SHALL latch lk_sel=in_sel and move to LOCKED.
REQ-019 A transfer with in_last=1 in LOCKED SHALL return to IDLE; a transfer with in_last=1 in IDLE SHALL stay in IDLE (single-beat packet).
REQ-020 In LOCKED, in_sel SHALL be ignored until the last beat transfers.
REQ-021 Each channel SHALL hold a one-entry output register containing data, last and valid.
REQ-022 in_ready SHALL be combinational: 1 when the target register is empty or out_ready[target]=1.
REQ-023 An accepted beat SHALL appear on out_data/out_last of the target with out_valid set on the next cycle, giving 1-cycle latency.
REQ-024 A channel register SHALL clear out_valid when out_valid=1 and out_ready=1 and no new load occurs that cycle.
REQ-025 When a load and a drain occur in the same cycle, the register SHALL take the new beat and out_valid SHALL stay 1.
REQ-026 Non-target channels SHALL be unaffected by transfers.
- out_data of an invalid channel holds its last value.
REQ-027 Illegal select (target >= N, possible only when N is not a power of two) SHALL be handled as follows:
- in_ready=1;
- the beat is discarded;
- drop_cnt increments, saturating at 255;
- FSM transitions apply as for a legal beat.
REQ-028 out_valid[k] SHALL not depend combinationally on out_ready.
- in_ready may depend combinationally on out_ready[target], in_sel and the state.

Reset
REQ-029 rst_n=0 SHALL asynchronously force:
- state=IDLE, lk_sel=0;
- out_valid=0, out_last=0, out_data=0;
- drop_cnt=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet, and the next transfer after release SHALL be treated as a first beat.
REQ-031 While rst_n=0, in_ready SHALL be 0.

Structure
REQ-032 A shared package stream_demux_pkg SHALL hold:
- the FSM state enum (IDLE, LOCKED);
- the drop counter width constant (8);
- the clog2 helper.
REQ-033 The per-channel register SHALL be sub-module demux_out_reg, instantiated N times by a generate loop and parameterised by W.

Verification
REQ-034 (N=16, W=8) Single beat in_sel=4'h2, in_data=8'hA5, in_last=1, all out_ready=1 -> the next cycle gives out_valid=16'h0004, channel-2 data 8'hA5, out_last[2]=1, and the cycle after gives out_valid=0.
REQ-035 (N=16) 3-beat packet with sel=4'hB on beat 1 and in_sel changing to 4'h3 on beats 2-3 -> all three beats (8'h11, 8'h22, 8'h33) exit channel 11 in order, out_last[11] is set on 8'h33 only, and the FSM returns to IDLE.
REQ-036 (N=16) out_ready[5]=0 with two beats to channel 5 -> the first beat is held and in_ready=0 on the second; raising out_ready[5] gives in_ready=1 in the same cycle with a simultaneous drain and load, and out_valid[5] stays 1.
REQ-037 (N=12) 300 single-beat transfers with in_sel=4'hE -> in_ready=1 throughout, out_valid stays 0, and drop_cnt=255 (saturated).
REQ-038 (N=16) rst_n driven low asynchronously mid-cycle during a LOCKED packet to channel 7 -> outputs clear immediately; after release, a beat with in_sel=4'h1, in_last=1 is delivered on channel 1.
REQ-039 (N=16, W=8) Back-to-back single-beat packets to channels 0,15,0,15 with all out_ready=1 -> one transfer per cycle, each beat exits on the correct channel after 1 cycle, with no lost or duplicated beats.
